// File: rtl/ps2_arrow_keys.sv
// PS/2 keyboard receiver in the pixel clock domain; decodes extended arrow-key
// make/break sequences into held-level left/right/up/down outputs.
module ps2_arrow_keys #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic [7:0] oBYTE,
  output logic       oBYTE_VALID,
  output logic       oERR
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par_bit;
  logic [TO_W-1:0]        to_cnt;
  logic                   ext;
  logic                   brk;

  logic fall_c;
  logic dat_c;
  logic timeout_c;
  logic frame_done_c;
  logic frame_good_c;

  assign dat_c     = dat_sync[SYNC_STAGES-1];
  assign fall_c    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign timeout_c = (state != S_IDLE) && !fall_c && (to_cnt == TO_LAST);

  // Receiver next-state; a falling edge wins over a coincident timeout.
  always_comb begin
    state_nx     = state;
    frame_done_c = 1'b0;
    frame_good_c = 1'b0;
    if (timeout_c) begin
      state_nx = S_IDLE;
    end else if (fall_c) begin
      case (state)
        S_IDLE:   if (!dat_c) state_nx = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
        S_PARITY: state_nx = S_STOP;
        S_STOP: begin
          state_nx     = S_IDLE;
          frame_done_c = 1'b1;
          frame_good_c = (^{shift, par_bit}) & dat_c;
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Synchronisers, shift/parity capture and the inter-edge timeout counter.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], iPS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], iPS2_DAT};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      to_cnt   <= (state == S_IDLE || fall_c) ? '0 : to_cnt + TO_W'(1);
      if (fall_c) begin
        case (state)
          S_IDLE:   bit_cnt <= 3'd0;
          S_DATA: begin
            shift   <= {dat_c, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_c;
          default:  ;
        endcase
      end
    end
  end

  // Byte reporting and arrow-key decode; keys change alongside oBYTE_VALID.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      oBYTE       <= 8'd0;
      oBYTE_VALID <= 1'b0;
      oERR        <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      left        <= 1'b0;
      right       <= 1'b0;
      up          <= 1'b0;
      down        <= 1'b0;
    end else begin
      oBYTE_VALID <= frame_good_c;
      oERR        <= (frame_done_c & ~frame_good_c) | timeout_c;
      if (frame_good_c) begin
        oBYTE <= shift;
        case (shift)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          default: begin
            if (ext) begin
              case (shift)
                8'h75:   up    <= ~brk;
                8'h72:   down  <= ~brk;
                8'h6B:   left  <= ~brk;
                8'h74:   right <= ~brk;
                default: ;
              endcase
            end
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end else if (frame_done_c || timeout_c) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ps2_arrow_keys.md
Name: ps2_arrow_keys

Overview:
- Upstream input stage for the VGA display path.
- Receives PS/2 keyboard frames, decodes the extended arrow-key make/break sequences, and drives the held-level left/right/up/down inputs consumed by the VGA controller and square renderer.
- Runs entirely in the VGA pixel clock domain (25 MHz). Oversamples the asynchronous PS/2 clock and data lines.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on each PS/2 input line (minimum 2).
- TIMEOUT_CYCLES, 25000, idle cycles allowed between PS/2 clock falling edges mid-frame before the frame is aborted (1 ms at 25 MHz).

Ports:
- iVGA_CLK  input  1  pixel clock; the only clock.
- iRST_n  input  1  synchronous, active-low reset.
- iPS2_CLK  input  1  raw PS/2 clock from keyboard; asynchronous.
- iPS2_DAT  input  1  raw PS/2 data from keyboard; asynchronous.
- left  output  1  high while left arrow is held.
- right  output  1  high while right arrow is held.
- up  output  1  high while up arrow is held.
- down  output  1  high while down arrow is held.
- oBYTE  output  8  last correctly received scan byte.
- oBYTE_VALID  output  1  one-cycle pulse when oBYTE updates.
- oERR  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Clock and reset: one clock, iVGA_CLK. Reset is synchronous and active-low on iRST_n, sampled on the rising edge of iVGA_CLK.
- Reset values: all outputs 0; receiver in IDLE; bit count, timeout counter, ext and brk flags all 0. Synchroniser flops reset to 1 (PS/2 idle level).
- Reset asserted mid-frame discards the partial byte. No oERR pulse is generated.
- Edge detection: both lines pass through SYNC_STAGES flops. A falling edge is the synced clock going 1 in the previous cycle to 0 in the current cycle. Data is sampled from the synced data line in that same cycle.
- Receiver FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on a falling edge, except timeout.
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay (spurious edge ignored).
  - DATA: shift the bit into shift[7] with a right shift, so the byte ends up LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: go to IDLE. The frame is good if XOR(8 data bits, parity bit)=1 and stop bit=1.
    - Good frame: next cycle oBYTE=byte and oBYTE_VALID=1 for exactly one cycle.
    - Bad frame: next cycle oERR=1 for one cycle, oBYTE unchanged, ext and brk cleared.
- Timeout: the counter clears on every falling edge and while in IDLE; otherwise it increments. On reaching TIMEOUT_CYCLES-1 outside IDLE: return to IDLE, pulse oERR, clear ext and brk.
- Decoder, evaluated in the cycle oBYTE_VALID is high:
  - 0xE0 -> ext=1.
  - 0xF0 -> brk=1; ext is kept.
  - Any other byte with ext=1: if the byte is 0x75/0x72/0x6B/0x74, set up/down/left/right respectively to ~brk. Other keys are unchanged. Then clear ext and brk.
  - Any other byte with ext=0 (including keypad 0x75, 0xAA, 0xFA): no key change; clear ext and brk.
- Key outputs update in the same cycle as oBYTE_VALID, i.e. one cycle after the stop-bit edge.
- Multiple keys may be held simultaneously; each output is independent.
- Repeated make codes (typematic) leave a held key at 1.
- E0 F0 sequence with an unknown code: flags clear, no output change.
- Minimum PS/2 clock high/low time supported: SYNC_STAGES+2 cycles. Faster clocks are out of spec.

Test Plan:
- Send frames E0, 75 (PS/2 clock period 40 cycles) -> oBYTE_VALID pulses twice with oBYTE=0xE0 then 0x75; up=1 one cycle after the second stop edge; other keys remain 0.
- With up held, send E0, F0, 75 -> up=0 after the last frame. Then send E0 6B and E0 74 -> left=1 and right=1 simultaneously; send E0 F0 6B -> left=0, right stays 1.
- Send 0x75 without prefix -> oBYTE_VALID=1, oBYTE=0x75, up stays 0.
- Send E0 with a corrupted parity bit, then 75 -> oERR pulses once; the E0 byte is not reported; up stays 0 (ext never set).
- Stop toggling PS/2 clock after 4 data bits for TIMEOUT_CYCLES cycles -> oERR pulses once, FSM back in IDLE; the next full E0 72 frame pair sets down=1.
- Hold right=1, assert iRST_n=0 for one cycle mid-frame -> all outputs 0 next cycle; the remaining bits of the aborted frame produce at most an oERR and no spurious key.
